// File: rtl/vga_sync_if.sv
// vga_sync_if: bundle of the VGA timing outputs produced by vga_sync.
//
// Signals
//   p_tick   : one-clk-wide pixel-rate enable (1 in 4 clk cycles)
//   x        : current horizontal count, 0 .. H_TOTAL-1
//   y        : current vertical count,   0 .. V_TOTAL-1
//   video_on : high while (x, y) lies in the visible area
//   hsync    : horizontal sync, active-low
//   vsync    : vertical sync, active-low
//
// Modports
//   master : timing generator side (drives every signal)
//   slave  : consumer side (video pipeline, DAC, bench)
interface vga_sync_if;

    logic       p_tick;
    logic [9:0] x;
    logic [9:0] y;
    logic       video_on;
    logic       hsync;
    logic       vsync;

    modport master (
        output p_tick,
        output x,
        output y,
        output video_on,
        output hsync,
        output vsync
    );

    modport slave (
        input p_tick,
        input x,
        input y,
        input video_on,
        input hsync,
        input vsync
    );

endinterface

// File: rtl/vga_sync.sv
// vga_sync: VGA raster timing generator.
//
// A 2-bit divider turns the 100 MHz system clock into a 25 MHz pixel enable.
// The horizontal counter advances once per pixel enable and wraps at H_TOTAL;
// the vertical counter advances on each horizontal wrap and wraps at V_TOTAL.
// video_on, hsync and vsync are registered from the next-state counter values
// so they change on the same edge as x/y and never lag them.
//
// Ports
//   clk    : system clock, all state on its rising edge
//   reset  : synchronous, active-low reset
//   sync_o : vga_sync_if.master carrying p_tick, x, y, video_on, hsync, vsync
module vga_sync #(
    parameter int unsigned H_DISPLAY = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_DISPLAY = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33
) (
    input  logic       clk,
    input  logic       reset,
    vga_sync_if.master sync_o
);

    localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    // 10-bit copies of the boundaries so every comparison is width-matched.
    localparam logic [9:0] HMax       = 10'(H_TOTAL - 1);
    localparam logic [9:0] VMax       = 10'(V_TOTAL - 1);
    localparam logic [9:0] HDisp      = 10'(H_DISPLAY);
    localparam logic [9:0] VDisp      = 10'(V_DISPLAY);
    localparam logic [9:0] HSyncStart = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HSyncEnd   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VSyncStart = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VSyncEnd   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic [1:0] div_q, div_d;
    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic       p_tick_q, p_tick_d;
    logic       video_on_q, video_on_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       adv;

    // Counters only move in the divider's last phase; p_tick is that phase
    // registered, so it is high in the cycle where the new x is visible.
    assign adv = (div_q == 2'd3);

    always_comb begin
        div_d    = div_q + 2'd1;
        x_d      = x_q;
        y_d      = y_q;
        p_tick_d = adv;

        if (adv) begin
            if (x_q == HMax) begin
                x_d = '0;
                y_d = (y_q == VMax) ? '0 : y_q + 10'd1;
            end else begin
                x_d = x_q + 10'd1;
            end
        end

        // Decode from next-state counters so outputs align with x/y.
        video_on_d = (x_d < HDisp) && (y_d < VDisp);
        hsync_d    = !((x_d >= HSyncStart) && (x_d <= HSyncEnd));
        vsync_d    = !((y_d >= VSyncStart) && (y_d <= VSyncEnd));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            div_q      <= '0;
            x_q        <= '0;
            y_q        <= '0;
            p_tick_q   <= 1'b0;
            video_on_q <= 1'b0;
            hsync_q    <= 1'b1;
            vsync_q    <= 1'b1;
        end else begin
            div_q      <= div_d;
            x_q        <= x_d;
            y_q        <= y_d;
            p_tick_q   <= p_tick_d;
            video_on_q <= video_on_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
        end
    end

    assign sync_o.p_tick   = p_tick_q;
    assign sync_o.x        = x_q;
    assign sync_o.y        = y_q;
    assign sync_o.video_on = video_on_q;
    assign sync_o.hsync    = hsync_q;
    assign sync_o.vsync    = vsync_q;

endmodule

// File: tb/tb_vga_sync.sv
// tb_vga_sync: checks two vga_sync instances every clk cycle against a
// reference model that derives the expected raster position purely from the
// number of clk edges seen since reset was last released.
//   u_big   : default 640x480 timing, one uninterrupted release, covers the
//             reset sequence and the first lines (hsync window, x wrap, y step)
//   u_small : tiny raster so many full frames fit, with random reset pulses
module tb_vga_sync;

    // Small raster geometry: H_TOTAL = 23, V_TOTAL = 19.
    localparam int SHD = 16, SHF = 2, SHS = 3, SHB = 2;
    localparam int SVD = 12, SVF = 2, SVS = 2, SVB = 3;
    localparam int NCycles = 12000;

    logic clk;
    logic rst_big;
    logic rst_small;

    int n_checks;
    int n_errors;

    vga_sync_if if_big ();
    vga_sync_if if_small ();

    vga_sync u_big (
        .clk    (clk),
        .reset  (rst_big),
        .sync_o (if_big)
    );

    vga_sync #(
        .H_DISPLAY (SHD),
        .H_FRONT   (SHF),
        .H_SYNC    (SHS),
        .H_BACK    (SHB),
        .V_DISPLAY (SVD),
        .V_FRONT   (SVF),
        .V_SYNC    (SVS),
        .V_BACK    (SVB)
    ) u_small (
        .clk    (clk),
        .reset  (rst_small),
        .sync_o (if_small)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Expected outputs after 'e' clk edges with reset high (e == 0: in reset).
    // Pixel index n = e/4 walks the raster in row-major order.
    typedef struct packed {
        logic       p_tick;
        logic [9:0] x;
        logic [9:0] y;
        logic       video_on;
        logic       hsync;
        logic       vsync;
    } exp_t;

    function automatic exp_t model(input int e, input int hd, input int hf, input int hs,
                                   input int hb, input int vd, input int vf, input int vs,
                                   input int vb);
        exp_t r;
        int ht, vt, pos, px, py;
        ht = hd + hf + hs + hb;
        vt = vd + vf + vs + vb;
        if (e == 0) begin
            r = '{p_tick: 1'b0, x: 10'd0, y: 10'd0, video_on: 1'b0, hsync: 1'b1, vsync: 1'b1};
        end else begin
            pos = (e / 4) % (ht * vt);
            px  = pos % ht;
            py  = pos / ht;
            r.p_tick   = (e % 4 == 0);
            r.x        = 10'(px);
            r.y        = 10'(py);
            r.video_on = (px < hd) && (py < vd);
            r.hsync    = !(px >= hd + hf && px < hd + hf + hs);
            r.vsync    = !(py >= vd + vf && py < vd + vf + vs);
        end
        return r;
    endfunction

    task automatic check_all(input string who, input exp_t exp, input logic pt,
                             input logic [9:0] x, input logic [9:0] y, input logic vo,
                             input logic hs, input logic vs);
        check_eq({who, ".p_tick"},   int'(pt), int'(exp.p_tick));
        check_eq({who, ".x"},        int'(x),  int'(exp.x));
        check_eq({who, ".y"},        int'(y),  int'(exp.y));
        check_eq({who, ".video_on"}, int'(vo), int'(exp.video_on));
        check_eq({who, ".hsync"},    int'(hs), int'(exp.hsync));
        check_eq({who, ".vsync"},    int'(vs), int'(exp.vsync));
    endtask

    initial begin
        int e_big, e_small, rst_left;
        exp_t eb, es;
        n_checks  = 0;
        n_errors  = 0;
        e_big     = 0;
        e_small   = 0;
        rst_left  = 0;
        rst_big   = 1'b0;
        rst_small = 1'b0;

        for (int i = 0; i < NCycles; i++) begin
            @(posedge clk);
            e_big   = rst_big   ? e_big + 1   : 0;
            e_small = rst_small ? e_small + 1 : 0;

            @(negedge clk);
            eb = model(e_big, 640, 16, 96, 48, 480, 10, 2, 33);
            es = model(e_small, SHD, SHF, SHS, SHB, SVD, SVF, SVS, SVB);
            check_all("big", eb, if_big.p_tick, if_big.x, if_big.y, if_big.video_on,
                      if_big.hsync, if_big.vsync);
            check_all("small", es, if_small.p_tick, if_small.x, if_small.y,
                      if_small.video_on, if_small.hsync, if_small.vsync);

            // Both held in reset for the first 5 edges, then released.
            rst_big = (i >= 4);
            if (i < 4) begin
                rst_small = 1'b0;
            end else if (rst_left > 0) begin
                rst_small = 1'b0;
                rst_left--;
            end else if ($urandom_range(0, 899) == 0) begin
                rst_small = 1'b0;
                rst_left  = $urandom_range(0, 2);
            end else begin
                rst_small = 1'b1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
